// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter behind a small byte FIFO.
// Ports: CLK, reset (async, active-high); DataIn/DataInValid/DataInReady
//   write side; SOut serial line (idles high); TxBusy frame-or-queue flag;
//   FifoCount bytes queued, not counting the byte being shifted.
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        CLK,
   input  logic                        reset,
   input  logic [7:0]                  DataIn,
   input  logic                        DataInValid,
   output logic                        DataInReady,
   output logic                        SOut,
   output logic                        TxBusy,
   output logic [$clog2(FIFO_DEPTH):0] FifoCount
);

   localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state;
   state_t        state_n;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [NW-1:0] count;
   logic [9:0]    shift;
   logic [9:0]    shift_n;
   logic [CW-1:0] bit_cnt;
   logic [CW-1:0] bit_cnt_n;
   logic [3:0]    bit_idx;
   logic [3:0]    bit_idx_n;
   logic          sout;
   logic          sout_n;
   logic          push;
   logic          pop;
   logic          have_data;
   logic          bit_end;
   logic          frame_end;

   assign have_data   = (count != '0);
   assign DataInReady = (count != FULL);
   assign push        = DataInValid && DataInReady;
   assign bit_end     = (bit_cnt == BIT_LAST);
   assign frame_end   = bit_end && (bit_idx == 4'd9);

   assign SOut      = sout;
   assign TxBusy    = (state == SHIFT) || have_data;
   assign FifoCount = count;

   always_ff @(posedge CLK) begin
      if (push) mem[wptr] <= DataIn;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + NW'(1);
            2'b01:   count <= count - NW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  if (have_data) state_n = SHIFT;
         SHIFT: if (frame_end && !have_data) state_n = IDLE;
      endcase
   end

   // Frame datapath; the line register is loaded from the next shift value
   // so the start bit appears on the edge that pops the byte.
   always_comb begin
      pop       = 1'b0;
      shift_n   = shift;
      bit_cnt_n = bit_cnt;
      bit_idx_n = bit_idx;
      unique case (state)
         IDLE: begin
            if (have_data) begin
               pop       = 1'b1;
               shift_n   = {1'b1, mem[rptr], 1'b0};
               bit_cnt_n = '0;
               bit_idx_n = '0;
            end
         end
         SHIFT: begin
            if (frame_end && have_data) begin
               pop       = 1'b1;
               shift_n   = {1'b1, mem[rptr], 1'b0};
               bit_cnt_n = '0;
               bit_idx_n = '0;
            end else if (bit_end) begin
               shift_n   = {1'b1, shift[9:1]};
               bit_cnt_n = '0;
               bit_idx_n = bit_idx + 4'd1;
            end else begin
               bit_cnt_n = bit_cnt + CW'(1);
            end
         end
      endcase
      sout_n = (state_n == SHIFT) ? shift_n[0] : 1'b1;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         shift   <= '1;
         bit_cnt <= '0;
         bit_idx <= '0;
         sout    <= 1'b1;
      end else begin
         shift   <= shift_n;
         bit_cnt <= bit_cnt_n;
         bit_idx <= bit_idx_n;
         sout    <= sout_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo against a queue and
// frame-time reference model, plus a serial receiver on SOut.
module tb_uart_tx_fifo;

   localparam int BITC  = 10;
   localparam int FRAME = 10 * BITC;
   localparam int DEPTH = 4;

   logic       CLK;
   logic       reset;
   logic [7:0] DataIn;
   logic       DataInValid;
   logic       DataInReady;
   logic       SOut;
   logic       TxBusy;
   logic [2:0] FifoCount;
   logic [5:0] obs;

   int vectors = 0;
   int errors  = 0;

   uart_tx_fifo #(
      .CLOCK_FREQ(100),
      .BAUD_RATE(10),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .CLK(CLK),
      .reset(reset),
      .DataIn(DataIn),
      .DataInValid(DataInValid),
      .DataInReady(DataInReady),
      .SOut(SOut),
      .TxBusy(TxBusy),
      .FifoCount(FifoCount)
   );

   assign obs = {SOut, DataInReady, TxBusy, FifoCount};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: queued bytes, and time into the current frame.
   logic [7:0] mq[$];
   logic [7:0] sent[$];
   bit         m_active;
   int         m_t;
   logic [7:0] m_cur;

   // Serial receiver state.
   logic [7:0] rx_q[$];
   bit         rx_on;
   int         rx_t;
   logic [7:0] rx_byte;

   function automatic void model_reset();
      mq.delete();
      m_active = 1'b0;
      m_t = 0;
   endfunction

   function automatic void model_edge(input logic v, input logic [7:0] d);
      bit rdy;
      rdy = (mq.size() != DEPTH);
      if (m_active) begin
         m_t++;
         if (m_t == FRAME) begin
            if (mq.size() != 0) begin
               m_cur = mq.pop_front();
               sent.push_back(m_cur);
               m_t = 0;
            end else begin
               m_active = 1'b0;
            end
         end
      end else if (mq.size() != 0) begin
         m_cur = mq.pop_front();
         sent.push_back(m_cur);
         m_active = 1'b1;
         m_t = 0;
      end
      if (v && rdy) mq.push_back(d);
   endfunction

   function automatic logic [5:0] model_out();
      logic s;
      int   k;
      s = 1'b1;
      if (m_active) begin
         k = m_t / BITC;
         if (k == 0)      s = 1'b0;
         else if (k == 9) s = 1'b1;
         else             s = m_cur[k-1];
      end
      return {s, 1'(mq.size() != DEPTH),
              1'(m_active || mq.size() != 0), 3'(mq.size())};
   endfunction

   task automatic rx_step();
      if (!rx_on) begin
         if (SOut === 1'b0) begin
            rx_on = 1'b1;
            rx_t = 0;
         end
      end else begin
         rx_t++;
      end
      if (rx_on) begin
         if (rx_t % BITC == 5 && rx_t >= 15 && rx_t <= 85)
            rx_byte = {SOut, rx_byte[7:1]};
         if (rx_t == 95) rx_q.push_back(rx_byte);
         if (rx_t == FRAME - 1) rx_on = 1'b0;
      end
   endtask

   // Drive at a falling edge, let one rising edge pass, return at the
   // next falling edge with the model advanced.
   task automatic cycle(input logic v, input logic [7:0] d);
      DataInValid = v;
      DataIn = d;
      @(posedge CLK);
      model_edge(v, d);
      @(negedge CLK);
      DataInValid = 1'b0;
      rx_step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      DataInValid = 1'b0;
      DataIn = 8'h00;
      model_reset();
      rx_on = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      vectors++;
      if (obs !== 6'b110_000) begin
         errors++;
         $display("FAIL reset_vals got=%b want=110000", obs);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'h00);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL reset_idle cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
   endtask

   task automatic test_single();
      logic [9:0] mid;
      logic [9:0] want;
      want = {1'b1, 8'hA5, 1'b0};
      mid = '0;
      rx_q.delete();
      cycle(1'b1, 8'hA5);
      vectors++;
      if (obs !== model_out()) begin
         errors++;
         $display("FAIL single_push got=%b want=%b", obs, model_out());
      end
      cycle(1'b0, 8'h00);
      vectors++;
      if (SOut !== 1'b0) begin
         errors++;
         $display("FAIL single_start sout=%b want 0", SOut);
      end
      for (int i = 1; i < FRAME; i++) begin
         cycle(1'b0, 8'h00);
         if (i % BITC == 5) mid[i / BITC] = SOut;
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL single cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (mid !== want) begin
         errors++;
         $display("FAIL single_bits got=%b want=%b", mid, want);
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00);
      vectors++;
      if (TxBusy !== 1'b0 || SOut !== 1'b1) begin
         errors++;
         $display("FAIL single_end busy=%b sout=%b want 0 1", TxBusy, SOut);
      end
      vectors++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
         errors++;
         $display("FAIL single_rx n=%0d want 1 byte a5", rx_q.size());
      end
   endtask

   task automatic test_burst();
      rx_q.delete();
      for (int b = 1; b <= 5; b++) begin
         cycle(1'b1, 8'(b));
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL burst_push%0d got=%b want=%b", b, obs, model_out());
         end
      end
      vectors++;
      if (FifoCount !== 3'd4 || DataInReady !== 1'b0) begin
         errors++;
         $display("FAIL burst_full cnt=%0d rdy=%b want 4 0", FifoCount, DataInReady);
      end
      cycle(1'b1, 8'h06);
      vectors++;
      if (FifoCount !== 3'd4) begin
         errors++;
         $display("FAIL burst_drop cnt=%0d want 4", FifoCount);
      end
      for (int i = 0; i < 1000 && (m_active || mq.size() != 0); i++) begin
         cycle(1'b0, 8'h00);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL burst cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (TxBusy !== 1'b0) begin
         errors++;
         $display("FAIL burst_drain busy=%b want 0", TxBusy);
      end
      vectors++;
      if (rx_q.size() != 5) begin
         errors++;
         $display("FAIL burst_rx_n got=%0d want 5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rx_q[i] !== 8'(i + 1)) begin
               errors++;
               $display("FAIL burst_rx%0d got=%h want=%h", i, rx_q[i], 8'(i + 1));
            end
         end
      end
   endtask

   task automatic test_simul();
      int mn;
      rx_q.delete();
      sent.delete();
      mn = 99;
      for (int b = 0; b < 5; b++) cycle(1'b1, 8'($urandom));
      for (int i = 0; i < 130; i++) begin
         cycle(1'b1, 8'($urandom));
         if (int'(FifoCount) < mn) mn = int'(FifoCount);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL simul cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (mn != 3 || FifoCount !== 3'd4) begin
         errors++;
         $display("FAIL simul_refill min=%0d end=%0d want 3 4", mn, FifoCount);
      end
      for (int i = 0; i < 1000 && (m_active || mq.size() != 0); i++) begin
         cycle(1'b0, 8'h00);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL simul_drain cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (TxBusy !== 1'b0 || rx_q.size() != sent.size()) begin
         errors++;
         $display("FAIL simul_end busy=%b rx=%0d want 0 %0d", TxBusy, rx_q.size(), sent.size());
      end else begin
         for (int i = 0; i < sent.size(); i++) begin
            vectors++;
            if (rx_q[i] !== sent[i]) begin
               errors++;
               $display("FAIL simul_rx%0d got=%h want=%h", i, rx_q[i], sent[i]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      int         pushed;
      logic       v;
      logic [7:0] d;
      rx_q.delete();
      pushed = 0;
      for (int i = 0; i < 3000 && pushed < 10; i++) begin
         v = (mq.size() < 3) && ($urandom_range(0, 3) == 0);
         d = 8'h10 + 8'(pushed);
         cycle(v, d);
         if (v) pushed++;
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL wrap cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (pushed != 10) begin
         errors++;
         $display("FAIL wrap_pushes got=%0d want 10", pushed);
      end
      for (int i = 0; i < 1000 && (m_active || mq.size() != 0); i++) begin
         cycle(1'b0, 8'h00);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL wrap_drain cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (TxBusy !== 1'b0 || rx_q.size() != 10) begin
         errors++;
         $display("FAIL wrap_end busy=%b rx=%0d want 0 10", TxBusy, rx_q.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            vectors++;
            if (rx_q[i] !== 8'h10 + 8'(i)) begin
               errors++;
               $display("FAIL wrap_rx%0d got=%h want=%h", i, rx_q[i], 8'h10 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int         lows;
      logic [7:0] b;
      rx_q.delete();
      lows = 0;
      for (int k = 0; k < 3; k++) cycle(1'b1, 8'($urandom));
      for (int i = 0; i < 200 && m_t != 35; i++) begin
         cycle(1'b0, 8'h00);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL mrst_pre cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (FifoCount !== 3'd2 || m_t != 35) begin
         errors++;
         $display("FAIL mrst_setup cnt=%0d t=%0d want 2 35", FifoCount, m_t);
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (obs !== 6'b110_000) begin
         errors++;
         $display("FAIL mrst_async got=%b want=110000", obs);
      end
      model_reset();
      rx_on = 1'b0;
      @(negedge CLK);
      reset = 1'b0;
      for (int i = 0; i < 150; i++) begin
         cycle(1'b0, 8'h00);
         if (SOut !== 1'b1) lows++;
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL mrst_idle cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (lows != 0 || rx_q.size() != 0) begin
         errors++;
         $display("FAIL mrst_quiet lows=%0d rx=%0d want 0 0", lows, rx_q.size());
      end
      b = 8'($urandom);
      cycle(1'b1, b);
      for (int i = 0; i < 1000 && (m_active || mq.size() != 0); i++) begin
         cycle(1'b0, 8'h00);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL mrst_resume cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (rx_q.size() != 1 || rx_q[0] !== b) begin
         errors++;
         $display("FAIL mrst_rx n=%0d want 1 byte %h", rx_q.size(), b);
      end
   endtask

   task automatic test_full_hold();
      logic [7:0] exp[$];
      logic [7:0] b;
      rx_q.delete();
      for (int k = 0; k < 5; k++) begin
         b = 8'($urandom);
         exp.push_back(b);
         cycle(1'b1, b);
      end
      for (int i = 0; i < 50; i++) begin
         cycle(1'b1, 8'($urandom));
         vectors++;
         if (obs !== model_out() || FifoCount !== 3'd4) begin
            errors++;
            $display("FAIL hold cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      for (int i = 0; i < 1000 && (m_active || mq.size() != 0); i++) begin
         cycle(1'b0, 8'h00);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL hold_drain cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (rx_q.size() != 5) begin
         errors++;
         $display("FAIL hold_rx_n got=%0d want 5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rx_q[i] !== exp[i]) begin
               errors++;
               $display("FAIL hold_rx%0d got=%h want=%h", i, rx_q[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      int   rate;
      logic v;
      rx_q.delete();
      sent.delete();
      for (int i = 0; i < 2000; i++) begin
         rate = ((i / 300) % 2 == 1) ? 40 : 2;
         v = ($urandom_range(0, 99) < rate);
         cycle(v, 8'($urandom));
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL rand cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      for (int i = 0; i < 1000 && (m_active || mq.size() != 0); i++) begin
         cycle(1'b0, 8'h00);
         vectors++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL rand_drain cyc%0d got=%b want=%b", i, obs, model_out());
         end
      end
      vectors++;
      if (TxBusy !== 1'b0 || rx_q.size() != sent.size()) begin
         errors++;
         $display("FAIL rand_end busy=%b rx=%0d want 0 %0d", TxBusy, rx_q.size(), sent.size());
      end else begin
         for (int i = 0; i < sent.size(); i++) begin
            vectors++;
            if (rx_q[i] !== sent[i]) begin
               errors++;
               $display("FAIL rand_rx%0d got=%h want=%h", i, rx_q[i], sent[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_simul();
      test_wrap();
      test_mid_reset();
      test_full_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
